// File: rtl/game_pkg.sv
// Shared game definitions for the obstacle and screen blocks.
// Provides screen geometry, gamemode encoding and the obstacle FSM states.
package game_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned NUM_OBS = 10;

    typedef enum logic [1:0] {
        GM_START = 2'b00,
        GM_GAME  = 2'b01,
        GM_PAUSE = 2'b10,
        GM_END   = 2'b11
    } gamemode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_SPAWN
    } obs_state_t;

    // Lowest obstacle bottom edge must stay on screen for any random offset.
    function automatic bit y_range_ok(input int unsigned y_min, input int unsigned obs_h);
        return (y_min + 255 + obs_h) < V_RES;
    endfunction

endpackage

// File: rtl/lfsr_rand.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, seeded with 16'hACE1.
// Free-running: steps every cycle, cleared only by rst.
module lfsr_rand (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 16'hACE1;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/obstacle_ctrl.sv
// Obstacle slot owner: spawns at the right edge, scrolls left once per frame, retires at the left edge.
// Optional build macro OBSTACLE_SPEEDUP_EN raises scroll speed as spawns accumulate.
module obstacle_ctrl
    import game_pkg::*;
#(
    parameter int unsigned OBS_W          = 40,
    parameter int unsigned OBS_H          = 120,
    parameter int unsigned SPEED          = 2,
    parameter int unsigned SPAWN_FRAMES   = 90,
    parameter int unsigned Y_MIN          = 32,
    parameter int unsigned MAX_SPEED      = 8,
    parameter int unsigned SPEEDUP_SPAWNS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic [1:0]      gamemode,
    output logic [9:0][9:0] obstacle_x_game_left,
    output logic [9:0][9:0] obstacle_x_game_right,
    output logic [9:0][8:0] obstacle_y_game_up,
    output logic [9:0][8:0] obstacle_y_game_down,
    output logic [15:0]     passed_count,
    output logic            busy
);

    localparam int unsigned CW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW-1:0] FRAME_LAST = CW'(SPAWN_FRAMES - 1);
    localparam logic [9:0] SPAWN_L = 10'(H_RES);
    localparam logic [9:0] SPAWN_R = 10'(H_RES + OBS_W);

    if (!y_range_ok(Y_MIN, OBS_H)) begin : g_y_range_check
        $error("obstacle_ctrl: Y_MIN + 255 + OBS_H must be below V_RES");
    end

    gamemode_t     gm;
    obs_state_t    state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [CW-1:0] frame_cnt;
    logic [15:0]   rnd;
    logic [9:0]    spd;
    logic [9:0]    cur_l, cur_r;
    logic          free_found;
    logic [3:0]    free_idx;
    logic [8:0]    spawn_up;
    logic          unused_rnd_hi;

    assign gm            = gamemode_t'(gamemode);
    assign busy          = (state != ST_IDLE);
    assign cur_l         = obstacle_x_game_left[idx];
    assign cur_r         = obstacle_x_game_right[idx];
    assign spawn_up      = 9'(Y_MIN) + {1'b0, rnd[7:0]};
    assign unused_rnd_hi = ^rnd[15:8];

    lfsr_rand u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (rnd)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (frame_tick && gm == GM_GAME) begin
                    state_nxt = ST_UPDATE;
                    idx_nxt   = '0;
                end
            end
            ST_UPDATE: begin
                if (idx == 4'(NUM_OBS - 1)) begin
                    state_nxt = ST_SPAWN;
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end
            ST_SPAWN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            if (!free_found && obstacle_x_game_right[i] == '0) begin
                free_found = 1'b1;
                free_idx   = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || gm == GM_START) begin
            state                 <= ST_IDLE;
            idx                   <= '0;
            frame_cnt             <= '0;
            passed_count          <= '0;
            obstacle_x_game_left  <= '0;
            obstacle_x_game_right <= '0;
            obstacle_y_game_up    <= '0;
            obstacle_y_game_down  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == ST_UPDATE && cur_r != '0) begin
                if (cur_r <= spd) begin
                    obstacle_x_game_left[idx]  <= '0;
                    obstacle_x_game_right[idx] <= '0;
                    obstacle_y_game_up[idx]    <= '0;
                    obstacle_y_game_down[idx]  <= '0;
                    if (passed_count != '1) begin
                        passed_count <= passed_count + 16'd1;
                    end
                end else begin
                    obstacle_x_game_right[idx] <= cur_r - spd;
                    obstacle_x_game_left[idx]  <= (cur_l > spd) ? cur_l - spd : '0;
                end
            end
            // The counter wraps even when every slot is occupied and the spawn is dropped.
            if (state == ST_SPAWN) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    if (free_found) begin
                        obstacle_x_game_left[free_idx]  <= SPAWN_L;
                        obstacle_x_game_right[free_idx] <= SPAWN_R;
                        obstacle_y_game_up[free_idx]    <= spawn_up;
                        obstacle_y_game_down[free_idx]  <= spawn_up + 9'(OBS_H);
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int unsigned SCW = (SPEEDUP_SPAWNS > 1) ? $clog2(SPEEDUP_SPAWNS) : 1;
    localparam logic [SCW-1:0] SPAWNS_LAST = SCW'(SPEEDUP_SPAWNS - 1);

    logic [SCW-1:0] spawn_cnt;
    logic           spawn_ok;

    assign spawn_ok = (state == ST_SPAWN) && (frame_cnt == FRAME_LAST) && free_found;

    always_ff @(posedge clk) begin
        if (rst || gm == GM_START) begin
            spd       <= 10'(SPEED);
            spawn_cnt <= '0;
        end else if (spawn_ok) begin
            if (spawn_cnt == SPAWNS_LAST) begin
                spawn_cnt <= '0;
                if (spd < 10'(MAX_SPEED)) begin
                    spd <= spd + 10'd1;
                end
            end else begin
                spawn_cnt <= spawn_cnt + 1'b1;
            end
        end
    end
`else
    assign spd = 10'(SPEED);
`endif

endmodule

// File: tb/tb_obstacle_ctrl.sv
// Directed self-checking bench for obstacle_ctrl: default instance plus a
// one-frame-spawn, speed-1 instance for the full-array case.
module tb_obstacle_ctrl;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_tick, frame_tick2;
    logic [1:0]      gamemode, gamemode2;
    logic [9:0][9:0] xl, xr, xl2, xr2;
    logic [9:0][8:0] yu, yd, yu2, yd2;
    logic [15:0]     passed, passed2;
    logic            busy, busy2;

    int vectors    = 0;
    int miscompares = 0;
    logic [15:0] m_lfsr;
    logic [15:0] last_rnd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    obstacle_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .frame_tick            (frame_tick),
        .gamemode              (gamemode),
        .obstacle_x_game_left  (xl),
        .obstacle_x_game_right (xr),
        .obstacle_y_game_up    (yu),
        .obstacle_y_game_down  (yd),
        .passed_count          (passed),
        .busy                  (busy)
    );

    obstacle_ctrl #(.SPAWN_FRAMES(1), .SPEED(1)) dut_full (
        .clk                   (clk),
        .rst                   (rst),
        .frame_tick            (frame_tick2),
        .gamemode              (gamemode2),
        .obstacle_x_game_left  (xl2),
        .obstacle_x_game_right (xr2),
        .obstacle_y_game_up    (yu2),
        .obstacle_y_game_down  (yd2),
        .passed_count          (passed2),
        .busy                  (busy2)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame pulse; exp_hi < 0 skips the busy-length check; dup re-pulses mid-sweep.
    task automatic tick(input int exp_hi, input bit dup, input bit sel);
        int hi = 0;
        @(negedge clk);
        if (sel) frame_tick2 = 1'b1; else frame_tick = 1'b1;
        @(negedge clk);
        frame_tick  = 1'b0;
        frame_tick2 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            if (dup && i == 4) frame_tick = 1'b1;
            if (dup && i == 5) frame_tick = 1'b0;
            if (sel ? busy2 : busy) hi++;
            if (i == 10) last_rnd = m_lfsr;
        end
        @(negedge clk);
        if (sel ? busy2 : busy) hi++;
        if (exp_hi >= 0) begin
            vectors++;
            if (hi != exp_hi) begin
                miscompares++;
                $display("FAIL busy_cycles: got %0d expected %0d", hi, exp_hi);
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; gamemode = 2'b01; gamemode2 = 2'b00;
        frame_tick = 1'b0; frame_tick2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++)
            if (xl[i] !== 10'd0 || xr[i] !== 10'd0 || yu[i] !== 9'd0 || yd[i] !== 9'd0) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset_slots: got %0d nonzero slots expected 0", bad);
        end
        vectors++;
        if (passed !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_status: got passed=%0d busy=%b expected 0/0", passed, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_spawn();
        int bad = 0;
        logic [8:0] ey;
        gamemode = 2'b01;
        for (int k = 1; k < 90; k++) tick(11, 1'b0, 1'b0);
        vectors++;
        if (xr[0] !== 10'd0) begin
            miscompares++;
            $display("FAIL early_spawn: got right=%0d expected 0", xr[0]);
        end
        tick(11, 1'b0, 1'b0);
        ey = 9'd32 + {1'b0, last_rnd[7:0]};
        vectors++;
        if (xl[0] !== 10'd640 || xr[0] !== 10'd680) begin
            miscompares++;
            $display("FAIL spawn_x: got %0d/%0d expected 640/680", xl[0], xr[0]);
        end
        vectors++;
        if (yu[0] !== ey || yd[0] !== ey + 9'd120) begin
            miscompares++;
            $display("FAIL spawn_y: got %0d/%0d expected %0d/%0d", yu[0], yd[0], ey, ey + 9'd120);
        end
        for (int i = 1; i < 10; i++)
            if (xl[i] !== 10'd0 || xr[i] !== 10'd0 || yu[i] !== 9'd0 || yd[i] !== 9'd0) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL other_slots: got %0d nonzero expected 0", bad);
        end
    endtask

    task automatic test_scroll();
        for (int k = 0; k < 10; k++) tick(11, 1'b0, 1'b0);
        vectors++;
        if (xl[0] !== 10'd620 || xr[0] !== 10'd660) begin
            miscompares++;
            $display("FAIL scroll: got %0d/%0d expected 620/660", xl[0], xr[0]);
        end
    endtask

    task automatic test_back_to_back();
        tick(11, 1'b1, 1'b0);
        vectors++;
        if (xl[0] !== 10'd618 || xr[0] !== 10'd658) begin
            miscompares++;
            $display("FAIL tick_while_busy: got %0d/%0d expected 618/658", xl[0], xr[0]);
        end
    endtask

    task automatic test_retire();
        for (int k = 0; k < 308; k++) tick(-1, 1'b0, 1'b0);
        vectors++;
        if (xl[0] !== 10'd2 || xr[0] !== 10'd42) begin
            miscompares++;
            $display("FAIL pre_clamp: got %0d/%0d expected 2/42", xl[0], xr[0]);
        end
        tick(-1, 1'b0, 1'b0);
        vectors++;
        if (xl[0] !== 10'd0 || xr[0] !== 10'd40) begin
            miscompares++;
            $display("FAIL left_clamp: got %0d/%0d expected 0/40", xl[0], xr[0]);
        end
        vectors++;
        if (xl[1] !== 10'd180 || xr[1] !== 10'd220) begin
            miscompares++;
            $display("FAIL second_obs: got %0d/%0d expected 180/220", xl[1], xr[1]);
        end
        for (int k = 0; k < 19; k++) tick(-1, 1'b0, 1'b0);
        vectors++;
        if (xr[0] !== 10'd2 || passed !== 16'd0) begin
            miscompares++;
            $display("FAIL pre_retire: got right=%0d passed=%0d expected 2/0", xr[0], passed);
        end
        tick(11, 1'b0, 1'b0);
        vectors++;
        if (xl[0] !== 10'd0 || xr[0] !== 10'd0 || yu[0] !== 9'd0 || yd[0] !== 9'd0 || passed !== 16'd1) begin
            miscompares++;
            $display("FAIL retire: got l=%0d r=%0d u=%0d d=%0d passed=%0d expected 0/0/0/0/1",
                     xl[0], xr[0], yu[0], yd[0], passed);
        end
    endtask

    task automatic test_pause();
        logic [8:0] ey;
        gamemode = 2'b10;
        for (int k = 0; k < 20; k++) tick(0, 1'b0, 1'b0);
        vectors++;
        if (xr[0] !== 10'd0 || xl[1] !== 10'd140 || xr[1] !== 10'd180 || xl[2] !== 10'd320 ||
            xr[2] !== 10'd360 || xl[3] !== 10'd500 || xr[3] !== 10'd540 || xr[4] !== 10'd0 ||
            passed !== 16'd1) begin
            miscompares++;
            $display("FAIL pause_hold: got r0=%0d s1=%0d/%0d s2=%0d/%0d s3=%0d/%0d r4=%0d passed=%0d expected 0 140/180 320/360 500/540 0 1",
                     xr[0], xl[1], xr[1], xl[2], xr[2], xl[3], xr[3], xr[4], passed);
        end
        gamemode = 2'b01;
        for (int k = 0; k < 19; k++) tick(-1, 1'b0, 1'b0);
        vectors++;
        if (xr[0] !== 10'd0) begin
            miscompares++;
            $display("FAIL resume_early: got right=%0d expected 0", xr[0]);
        end
        tick(11, 1'b0, 1'b0);
        ey = 9'd32 + {1'b0, last_rnd[7:0]};
        vectors++;
        if (xl[0] !== 10'd640 || xr[0] !== 10'd680 || yu[0] !== ey || xl[1] !== 10'd100) begin
            miscompares++;
            $display("FAIL resume_spawn: got %0d/%0d y=%0d l1=%0d expected 640/680 y=%0d l1=100",
                     xl[0], xr[0], yu[0], xl[1], ey);
        end
    endtask

    task automatic test_start_mid_sweep();
        int bad = 0;
        logic [8:0] ey;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); gamemode = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 10; i++)
            if (xl[i] !== 10'd0 || xr[i] !== 10'd0 || yu[i] !== 9'd0 || yd[i] !== 9'd0) bad++;
        vectors++;
        if (bad != 0 || passed !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_clear: got nonzero=%0d passed=%0d busy=%b expected 0/0/0", bad, passed, busy);
        end
        @(negedge clk); gamemode = 2'b01;
        for (int k = 1; k < 90; k++) tick(-1, 1'b0, 1'b0);
        vectors++;
        if (xr[0] !== 10'd0) begin
            miscompares++;
            $display("FAIL restart_early: got right=%0d expected 0", xr[0]);
        end
        tick(11, 1'b0, 1'b0);
        ey = 9'd32 + {1'b0, last_rnd[7:0]};
        vectors++;
        if (xl[0] !== 10'd640 || xr[0] !== 10'd680 || yu[0] !== ey || yd[0] !== ey + 9'd120) begin
            miscompares++;
            $display("FAIL restart_spawn: got %0d/%0d %0d/%0d expected 640/680 %0d/%0d",
                     xl[0], xr[0], yu[0], yd[0], ey, ey + 9'd120);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        gamemode2 = 2'b01;
        for (int k = 0; k < 10; k++) tick(11, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            if (xr2[i] !== 10'd680 - 10'(9 - i) || xl2[i] !== 10'd640 - 10'(9 - i)) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL full_fill: got %0d slots wrong expected 0 (slot0 %0d/%0d)", bad, xl2[0], xr2[0]);
        end
        tick(11, 1'b0, 1'b1);
        vectors++;
        if (xl2[0] !== 10'd630 || xr2[0] !== 10'd670 || xl2[9] !== 10'd639 || passed2 !== 16'd0) begin
            miscompares++;
            $display("FAIL full_skip: got s0=%0d/%0d l9=%0d passed=%0d expected 630/670 639 0",
                     xl2[0], xr2[0], xl2[9], passed2);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_scroll();
        test_back_to_back();
        test_retire();
        test_pause();
        test_start_mid_sweep();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
